// File: rtl/control_subcmd_drawrect_pkg.sv
// Shared types, panel geometry and clip arithmetic for the rectangle draw subcommand.
// The panel extents must not be powers of two: an address type has to hold the full
// panel size so that a full-width or full-height rectangle can be requested.
package control_subcmd_drawrect_pkg;

  localparam int unsigned BYTES_PER_PIXEL = 3;
  localparam int unsigned PIXEL_WIDTH     = 6;
  localparam int unsigned PIXEL_HEIGHT    = 5;

  localparam int unsigned ColW = $clog2(PIXEL_WIDTH);
  localparam int unsigned RowW = $clog2(PIXEL_HEIGHT);
  localparam int unsigned PixW = (BYTES_PER_PIXEL > 1) ? $clog2(BYTES_PER_PIXEL) : 1;
  // One bit wider than either axis so that origin + size never wraps.
  localparam int unsigned ExtW = ((ColW > RowW) ? ColW : RowW) + 1;

  typedef logic [ColW-1:0]              col_addr_t;
  typedef logic [RowW-1:0]              row_addr_t;
  typedef logic [PixW-1:0]              pixel_addr_t;
  typedef logic [8*BYTES_PER_PIXEL-1:0] color_t;
  typedef logic [7:0]                   mem_write_data_t;
  typedef logic [ExtW-1:0]              ext_t;

  typedef enum logic [1:0] {
    ModeSolid    = 2'd0,
    ModeOutline  = 2'd1,
    ModeChecker  = 2'd2,
    ModeReserved = 2'd3
  } draw_mode_t;

  // Operands captured at setup; x_hi/y_hi are the inclusive clipped far edges.
  typedef struct packed {
    draw_mode_t mode;
    col_addr_t  x_lo;
    col_addr_t  x_hi;
    row_addr_t  y_lo;
    row_addr_t  y_hi;
    color_t     color_a;
    color_t     color_b;
  } draw_ops_t;

  localparam ext_t ExtPanelW = ext_t'(PIXEL_WIDTH);
  localparam ext_t ExtPanelH = ext_t'(PIXEL_HEIGHT);

  // Number of cells of [origin, origin+size) that fall inside [0, limit).
  function automatic ext_t clip_extent(ext_t origin, ext_t size, ext_t limit);
    ext_t room;
    if (origin >= limit) return '0;
    room = limit - origin;
    return (size < room) ? size : room;
  endfunction

endpackage

// File: rtl/control_subcmd_drawrect_if.sv
// Request/response and RAM write bundle of the rectangle draw subcommand.
//   master: command decoder side (drives request operands, sees write stream and done)
//   slave : draw engine side
interface control_subcmd_drawrect_if;
  import control_subcmd_drawrect_pkg::*;

  logic            enable;
  logic            ack;
  draw_mode_t      mode;
  col_addr_t       x1;
  row_addr_t       y1;
  col_addr_t       width;
  row_addr_t       height;
  color_t          color_a;
  color_t          color_b;
  row_addr_t       row;
  col_addr_t       column;
  pixel_addr_t     pixel;
  mem_write_data_t data_out;
  logic            ram_write_enable;
  logic            ram_access_start;
  logic            done;

  modport master (
    output enable, ack, mode, x1, y1, width, height, color_a, color_b,
    input  row, column, pixel, data_out, ram_write_enable, ram_access_start, done
  );

  modport slave (
    input  enable, ack, mode, x1, y1, width, height, color_a, color_b,
    output row, column, pixel, data_out, ram_write_enable, ram_access_start, done
  );

endinterface

// File: rtl/control_subcmd_drawrect_scan_counter.sv
// Nested row/column/byte-lane down-counter for the rectangle scan.
//   load     : start at (row_hi, col_hi, lane BPP-1); row_lo/col_lo/col_hi are captured
//   step     : advance one byte (lane, then column wrapping to col_hi, then row)
//   row/column/pixel            : current position (registered)
//   row_next/column_next/pixel_next : position after this cycle, for registered consumers
//   last     : current position is (row_lo, col_lo, 0)
module control_subcmd_drawrect_scan_counter
  import control_subcmd_drawrect_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic        step,
  input  row_addr_t   row_hi,
  input  row_addr_t   row_lo,
  input  col_addr_t   col_hi,
  input  col_addr_t   col_lo,
  output row_addr_t   row,
  output col_addr_t   column,
  output pixel_addr_t pixel,
  output row_addr_t   row_next,
  output col_addr_t   column_next,
  output pixel_addr_t pixel_next,
  output logic        last
);

  localparam pixel_addr_t LaneTop = pixel_addr_t'(BYTES_PER_PIXEL - 1);

  row_addr_t   row_q, row_lo_q;
  col_addr_t   col_q, col_hi_q, col_lo_q;
  pixel_addr_t pix_q;

  always_comb begin
    row_next    = row_q;
    column_next = col_q;
    pixel_next  = pix_q;
    if (load) begin
      row_next    = row_hi;
      column_next = col_hi;
      pixel_next  = LaneTop;
    end else if (step) begin
      if (pix_q != '0) begin
        pixel_next = pix_q - pixel_addr_t'(1);
      end else begin
        pixel_next = LaneTop;
        if (col_q != col_lo_q) begin
          column_next = col_q - col_addr_t'(1);
        end else begin
          column_next = col_hi_q;
          row_next    = row_q - row_addr_t'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      row_q    <= '0;
      col_q    <= '0;
      pix_q    <= '0;
      row_lo_q <= '0;
      col_hi_q <= '0;
      col_lo_q <= '0;
    end else begin
      row_q <= row_next;
      col_q <= column_next;
      pix_q <= pixel_next;
      if (load) begin
        row_lo_q <= row_lo;
        col_hi_q <= col_hi;
        col_lo_q <= col_lo;
      end
    end
  end

  assign row    = row_q;
  assign column = col_q;
  assign pixel  = pix_q;
  assign last   = (row_q == row_lo_q) && (col_q == col_lo_q) && (pix_q == '0);

endmodule

// File: rtl/control_subcmd_drawrect.sv
// Rectangle draw subcommand: clips a requested rectangle to the panel and streams one
// framebuffer byte per clock (solid, outline or checker) to the RAM write port.
//   clk, reset : system clock, asynchronous active-high reset
//   bus        : enable/ack/done handshake, draw operands, RAM write address/data/strobes
module control_subcmd_drawrect
  import control_subcmd_drawrect_pkg::*;
(
  input logic                      clk,
  input logic                      reset,
  control_subcmd_drawrect_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StSetup, StWrite, StDone} state_e;

  state_e          state_q, state_d;
  draw_ops_t       ops_q, ops_d;
  ext_t            wc, hc;
  logic            load, step, write_slot;
  logic            we_q, we_d, start_q, start_d, done_q, done_d;
  mem_write_data_t data_q, data_d;
  color_t          sel;
  logic            on_edge;

  row_addr_t   cnt_row, cnt_row_next;
  col_addr_t   cnt_col, cnt_col_next;
  pixel_addr_t cnt_pix, cnt_pix_next;
  logic        cnt_last;

  control_subcmd_drawrect_scan_counter u_scan (
    .clk         (clk),
    .reset       (reset),
    .load        (load),
    .step        (step),
    .row_hi      (ops_d.y_hi),
    .row_lo      (ops_d.y_lo),
    .col_hi      (ops_d.x_hi),
    .col_lo      (ops_d.x_lo),
    .row         (cnt_row),
    .column      (cnt_col),
    .pixel       (cnt_pix),
    .row_next    (cnt_row_next),
    .column_next (cnt_col_next),
    .pixel_next  (cnt_pix_next),
    .last        (cnt_last)
  );

  // Sequencing: state, operand capture, counter control and handshake strobes.
  always_comb begin
    wc         = clip_extent(ext_t'(bus.x1), ext_t'(bus.width), ExtPanelW);
    hc         = clip_extent(ext_t'(bus.y1), ext_t'(bus.height), ExtPanelH);
    state_d    = state_q;
    ops_d      = ops_q;
    load       = 1'b0;
    step       = 1'b0;
    write_slot = 1'b0;
    start_d    = 1'b0;
    done_d     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.enable) state_d = StSetup;
      end
      StSetup: begin
        if (!bus.enable) begin
          state_d = StIdle;
        end else begin
          ops_d.mode    = bus.mode;
          ops_d.x_lo    = bus.x1;
          ops_d.y_lo    = bus.y1;
          ops_d.color_a = bus.color_a;
          ops_d.color_b = bus.color_b;
          if (wc == '0 || hc == '0) begin
            state_d = StDone;
            done_d  = 1'b1;
          end else begin
            ops_d.x_hi = col_addr_t'(ext_t'(bus.x1) + wc - ext_t'(1));
            ops_d.y_hi = row_addr_t'(ext_t'(bus.y1) + hc - ext_t'(1));
            load       = 1'b1;
            write_slot = 1'b1;
            start_d    = 1'b1;
            state_d    = StWrite;
          end
        end
      end
      StWrite: begin
        if (!bus.enable) begin
          state_d = StIdle;
        end else if (cnt_last) begin
          state_d = StDone;
          done_d  = 1'b1;
        end else begin
          step       = 1'b1;
          write_slot = 1'b1;
        end
      end
      StDone: begin
        if (bus.ack) state_d = StIdle;
        else         done_d  = 1'b1;
      end
      default: state_d = StIdle;
    endcase
  end

  // Byte generation for the position the counter moves to, so data and strobe register
  // alongside the address. Checker parity uses absolute panel coordinates.
  always_comb begin
    sel = ops_d.color_a;
    if (ops_d.mode == ModeChecker && (cnt_row_next[0] ^ cnt_col_next[0])) sel = ops_d.color_b;
    on_edge = (cnt_row_next == ops_d.y_lo) || (cnt_row_next == ops_d.y_hi) ||
              (cnt_col_next == ops_d.x_lo) || (cnt_col_next == ops_d.x_hi);
    we_d    = write_slot && ((ops_d.mode != ModeOutline) || on_edge);
    data_d  = write_slot ? mem_write_data_t'(sel >> {cnt_pix_next, 3'b000}) : data_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      ops_q   <= '0;
      we_q    <= 1'b0;
      start_q <= 1'b0;
      done_q  <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      ops_q   <= ops_d;
      we_q    <= we_d;
      start_q <= start_d;
      done_q  <= done_d;
      data_q  <= data_d;
    end
  end

  assign bus.row              = cnt_row;
  assign bus.column           = cnt_col;
  assign bus.pixel            = cnt_pix;
  assign bus.data_out         = data_q;
  assign bus.ram_write_enable = we_q;
  assign bus.ram_access_start = start_q;
  assign bus.done             = done_q;

endmodule

// File: tb/tb_control_subcmd_drawrect.sv
module tb_control_subcmd_drawrect;
  import control_subcmd_drawrect_pkg::*;

  typedef struct packed {
    row_addr_t       r;
    col_addr_t       c;
    pixel_addr_t     p;
    mem_write_data_t d;
  } wr_t;

  logic clk = 1'b0;
  logic reset;
  int   n_assert = 0;
  int   n_fail   = 0;
  wr_t  exp_q[$];

  always #5 clk = ~clk;

  control_subcmd_drawrect_if bus ();

  control_subcmd_drawrect dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: clip with plain min(), enumerate bytes in scan order, keep only strobed ones.
  task automatic model(input int mode, input int x1, input int y1, input int w, input int h,
                       input color_t ca, input color_t cb, output int n_cycles);
    int     wc, hc;
    bit     edge_px;
    color_t col;
    wr_t    e;
    exp_q.delete();
    wc = (x1 >= int'(PIXEL_WIDTH))  ? 0 : ((w < int'(PIXEL_WIDTH) - x1)  ? w : int'(PIXEL_WIDTH) - x1);
    hc = (y1 >= int'(PIXEL_HEIGHT)) ? 0 : ((h < int'(PIXEL_HEIGHT) - y1) ? h : int'(PIXEL_HEIGHT) - y1);
    n_cycles = wc * hc * int'(BYTES_PER_PIXEL);
    for (int r = y1 + hc - 1; r >= y1; r--) begin
      for (int c = x1 + wc - 1; c >= x1; c--) begin
        edge_px = (r == y1) || (r == y1 + hc - 1) || (c == x1) || (c == x1 + wc - 1);
        if (mode == 1 && !edge_px) continue;
        col = (mode == 2 && ((r ^ c) & 1) == 1) ? cb : ca;
        for (int p = int'(BYTES_PER_PIXEL) - 1; p >= 0; p--) begin
          e.r = row_addr_t'(r);
          e.c = col_addr_t'(c);
          e.p = pixel_addr_t'(p);
          e.d = col[p*8 +: 8];
          exp_q.push_back(e);
        end
      end
    end
  endtask

  task automatic drive_req(input int mode, input int x1, input int y1, input int w,
                           input int h, input color_t ca, input color_t cb);
    bus.mode    = draw_mode_t'(mode);
    bus.x1      = col_addr_t'(x1);
    bus.y1      = row_addr_t'(y1);
    bus.width   = col_addr_t'(w);
    bus.height  = row_addr_t'(h);
    bus.color_a = ca;
    bus.color_b = cb;
    bus.enable  = 1'b1;
  endtask

  task automatic run_rect(input string tag, input int mode, input int x1, input int y1,
                          input int w, input int h, input color_t ca, input color_t cb);
    int  n, k, starts, start_at, lim;
    bit  seen_done;
    wr_t got[$];
    wr_t g;
    model(mode, x1, y1, w, h, ca, cb, n);
    drive_req(mode, x1, y1, w, h, ca, cb);
    k = 0; starts = 0; start_at = -1; seen_done = 1'b0;
    while (!seen_done && k < 400) begin
      @(negedge clk);
      k++;
      // Operands must be ignored once latched.
      if (k == 2) begin
        bus.color_a = ~ca;
        bus.x1      = col_addr_t'(0);
        bus.width   = col_addr_t'(1);
      end
      if (bus.ram_write_enable) begin
        g.r = bus.row; g.c = bus.column; g.p = bus.pixel; g.d = bus.data_out;
        got.push_back(g);
      end
      if (bus.ram_access_start) begin
        starts++;
        start_at = k;
      end
      if (bus.done) seen_done = 1'b1;
    end
    check({tag, "/done_seen"}, 32'(seen_done), 32'd1);
    check({tag, "/done_latency"}, k, n + 2);
    check({tag, "/start_count"}, starts, (n > 0) ? 1 : 0);
    if (n > 0) check({tag, "/start_cycle"}, start_at, 2);
    check({tag, "/we_at_done"}, 32'(bus.ram_write_enable), 32'd0);
    check({tag, "/write_count"}, got.size(), exp_q.size());
    lim = (got.size() < exp_q.size()) ? got.size() : exp_q.size();
    for (int i = 0; i < lim; i++) check({tag, "/write"}, 32'(got[i]), 32'(exp_q[i]));
    bus.enable = 1'b0;
    @(negedge clk);
    check({tag, "/done_held"}, 32'(bus.done), 32'd1);
    bus.ack = 1'b1;
    @(negedge clk);
    bus.ack = 1'b0;
    check({tag, "/done_clear"}, 32'(bus.done), 32'd0);
  endtask

  function automatic logic [31:0] outs_flat();
    return 32'({bus.row, bus.column, bus.pixel, bus.data_out,
                bus.ram_write_enable, bus.ram_access_start, bus.done});
  endfunction

  initial begin
    reset      = 1'b1;
    bus.enable = 1'b0;
    bus.ack    = 1'b0;
    drive_req(0, 0, 0, 0, 0, '0, '0);
    bus.enable = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_outputs", outs_flat(), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Stray ack while idle must do nothing.
    bus.ack = 1'b1;
    @(negedge clk);
    bus.ack = 1'b0;
    check("idle_ack_ignored", 32'({bus.done, bus.ram_write_enable}), 32'd0);

    run_rect("solid_full", 0, 0, 0, int'(PIXEL_WIDTH), int'(PIXEL_HEIGHT),
             color_t'(24'hA5A5A5), color_t'(24'h0F0F0F));
    run_rect("clip", 0, int'(PIXEL_WIDTH) - 2, int'(PIXEL_HEIGHT) - 1, 7, 5,
             color_t'(24'h123456), color_t'(24'h654321));
    run_rect("outline_4x3", 1, 1, 1, 4, 3, color_t'(24'hC33C5A), color_t'(24'hFFFFFF));
    run_rect("checker_00", 2, 0, 0, 3, 3, color_t'(24'h000000), color_t'(24'hFFFFFF));
    run_rect("checker_10", 2, 1, 0, 3, 3, color_t'(24'h000000), color_t'(24'hFFFFFF));
    run_rect("width_zero", 0, 2, 2, 0, 3, color_t'(24'h111111), color_t'(24'h222222));
    run_rect("x_off_panel", 0, int'(PIXEL_WIDTH), 0, 3, 3, color_t'(24'h333333), '0);
    run_rect("height_zero", 1, 0, 1, 4, 0, color_t'(24'h444444), '0);
    run_rect("outline_col_strip", 1, 2, 0, 1, 4, color_t'(24'h5A6B7C), '0);
    run_rect("outline_row_strip", 1, 0, 3, 5, 1, color_t'(24'h8899AA), '0);
    run_rect("mode_reserved", 3, 1, 2, 2, 2, color_t'(24'hDEADBE), color_t'(24'h010203));

    // Abort mid-write: strobe drops the next cycle and done never appears.
    drive_req(0, 0, 0, int'(PIXEL_WIDTH), int'(PIXEL_HEIGHT), color_t'(24'h777777), '0);
    repeat (10) @(negedge clk);
    check("abort_pre_we", 32'(bus.ram_write_enable), 32'd1);
    bus.enable = 1'b0;
    @(negedge clk);
    check("abort_we_drop", 32'(bus.ram_write_enable), 32'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("abort_quiet", 32'({bus.done, bus.ram_write_enable, bus.ram_access_start}), 32'd0);
    end
    run_rect("after_abort", 0, 1, 1, 2, 2, color_t'(24'h9A9B9C), '0);

    // Asynchronous reset mid-write clears outputs without waiting for a clock edge.
    drive_req(2, 0, 0, int'(PIXEL_WIDTH), int'(PIXEL_HEIGHT),
              color_t'(24'hF0F1F2), color_t'(24'h0A0B0C));
    repeat (7) @(negedge clk);
    check("pre_reset_busy", 32'(bus.ram_write_enable), 32'd1);
    reset = 1'b1;
    #1;
    check("async_reset_outputs", outs_flat(), 32'd0);
    bus.enable = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    run_rect("after_reset", 0, 3, 2, 3, 3, color_t'(24'hABCDEF), '0);

    for (int t = 0; t < 10; t++) begin
      run_rect("random", int'($urandom_range(0, 3)), int'($urandom_range(0, 7)),
               int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
               int'($urandom_range(0, 7)), color_t'($urandom), color_t'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/control_subcmd_drawrect.md
Name: control_subcmd_drawrect

Overview:
Multi-mode rectangle draw subcommand that streams one framebuffer byte per clock to the RAM write port. It generalises the full-frame fill to:
- arbitrary origin and size, clipped to the panel;
- three draw modes: solid, outline, checker;
- two colour operands.

It sits under the control command decoder beside the other control_subcmd_* blocks and uses the same enable/ack/done handshake and {row, column, pixel} addressing.

Parameters:
BYTES_PER_PIXEL, params::BYTES_PER_PIXEL, bytes per pixel; byte lane index is `pixel`.
PIXEL_WIDTH, params::PIXEL_WIDTH, panel columns; clip bound for x.
PIXEL_HEIGHT, params::PIXEL_HEIGHT, panel rows; clip bound for y.

Ports:
clk  in  1  system clock; all state on posedge.
reset  in  1  asynchronous, active-high reset.
enable  in  1  request; held high for the whole operation.
ack  in  1  acknowledges done; one-cycle pulse.
mode  in  types::draw_mode_t (2)  SOLID=0, OUTLINE=1, CHECKER=2; 3 is reserved and behaves as SOLID.
x1  in  types::col_addr_t  left column.
y1  in  types::row_addr_t  top row.
width  in  types::col_addr_t  column count.
height  in  types::row_addr_t  row count.
color_a  in  types::color_t  primary colour.
color_b  in  types::color_t  checker odd-parity colour.
row  out  types::row_addr_t  write row.
column  out  types::col_addr_t  write column.
pixel  out  types::pixel_addr_t  byte lane.
data_out  out  types::mem_write_data_t  write byte.
ram_write_enable  out  1  byte write strobe.
ram_access_start  out  1  one-cycle pulse at start of a write burst.
done  out  1  operation complete; held until ack.

Behaviour:
- Reset (async) values: state=IDLE; row, column, pixel, data_out = 0; ram_write_enable, ram_access_start, done = 0.
- States and transitions:
  - IDLE: enable=1 → SETUP.
  - SETUP: latch all operands and compute clipped bounds.
    - Clipped width wc = (x1 >= PIXEL_WIDTH) ? 0 : min(width, PIXEL_WIDTH - x1).
    - Clipped height hc is computed the same way on the y axis.
    - Arithmetic uses one extra bit so nothing wraps.
    - If wc==0 or hc==0 → DONE with no writes.
    - Otherwise → WRITE, pulsing ram_access_start for exactly that one cycle.
  - WRITE: one byte per cycle.
    - Scan order: row descends y1+hc-1 → y1; within a row, column descends x1+wc-1 → x1; within a pixel, byte lane descends BYTES_PER_PIXEL-1 → 0.
    - The cycle after the byte (y1, x1, 0) → DONE.
    - Latency from first write to done = wc*hc*BPP cycles.
  - DONE: done=1, ram_write_enable=0. ack=1 → IDLE next cycle.
- Outputs row, column, pixel and data_out are registered and valid in the same cycle as ram_write_enable.
- Byte lane selection: data_out = sel[(pixel+1)*8-1 -: 8].
- Colour selection (sel):
  - SOLID: sel = color_a.
  - CHECKER: sel = ((row ^ column) & 1) ? color_b : color_a, using absolute panel coordinates.
- Outline gating:
  - OUTLINE: ram_write_enable=1 only when row ∈ {y1, y1+hc-1} or column ∈ {x1, x1+wc-1}.
  - Interior cycles still advance the address with ram_write_enable=0, so cycle count is identical to SOLID.
  - Outline colour is color_a.
  - wc==1 or hc==1 gives a full (solid) strip.
- Operands are latched in SETUP; changes after SETUP are ignored until the next IDLE.
- enable deasserted in SETUP or WRITE: abort → IDLE next cycle. ram_write_enable drops at once, done is never asserted, and no partial-row completion occurs.
- enable low in DONE: wait for ack anyway.
- ack outside DONE: ignored.
- reset mid-operation: immediate return to reset values.

Decomposition:
- Add to the types package:
  - draw_mode_t enum.
  - Existing col_addr_t, row_addr_t, pixel_addr_t, color_t, mem_write_data_t.
- Add to the calc package: clip-width function clip_extent(origin, size, limit).
- One natural sub-module, rect_scan_counter: the nested row/column/byte down-counter with load, step and last flag. The mode/colour logic stays in the top.

Test Plan:
- SOLID, x1=0, y1=0, full panel, color_a=A5A5..: exactly W*H*BPP unique writes, all 0xA5. Row sequence H-1…0. done is asserted the cycle after the last write, and state is IDLE one cycle after ack.
- Clip: x1=W-2, width=10, y1=H-1, height=5: only columns W-1, W-2 and row H-1 are written, 2*BPP writes, no out-of-range address.
- OUTLINE, 4x3 rectangle at (1,1): writes only the 10 perimeter pixels. Total cycles equal SOLID (12*BPP); the two interior pixels are never written.
- CHECKER, color_a=0x00.., color_b=0xFF.., 3x3 at (0,0): data_out is 0xFF exactly when (row^col) is odd. Repeat at origin (1,0) to confirm absolute-coordinate parity.
- width=0 (or x1>=W): done is asserted 2 cycles after enable, with zero writes and no ram_access_start.
- Abort and reset:
  - Drop enable mid-WRITE: writes stop the next cycle, no done, IDLE; a fresh SOLID run then completes.
  - Assert reset mid-WRITE: all outputs are 0 asynchronously.
